// File: rtl/seq_pattern_gen.sv
// Serial frame transmitter: preamble, MSB-first payload, then an idle-zero gap.
// Serial state advances only on bit_en edges; payload acceptance ignores bit_en.
module seq_pattern_gen #(
  parameter int unsigned DATA_W            = 8,
  parameter int unsigned PRE_W             = 4,
  parameter logic [PRE_W-1:0] PREAMBLE     = PRE_W'(4'b1010),
  parameter int unsigned GAP_LEN           = 2,
  parameter int unsigned CNT_W             = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              sout,
  output logic              sout_valid,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned MAX_W = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int unsigned IDX_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int unsigned GAP_W = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;

  typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;

  state_t            state_q, state_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              sout_d, sout_valid_d, frame_done_d;
  logic [CNT_W-1:0]  frame_cnt_d;

  assign in_ready = (state_q == IDLE);
  assign busy     = ~in_ready;

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      shreg_q    <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      shreg_q    <= shreg_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      sout       <= sout_d;
      sout_valid <= sout_valid_d;
      frame_done <= frame_done_d;
      frame_cnt  <= frame_cnt_d;
    end
  end

  // Next-state and next-output logic; everything holds unless bit_en (or an accept).
  always_comb begin
    state_d      = state_q;
    pre_d        = pre_q;
    shreg_d      = shreg_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    sout_d       = sout;
    sout_valid_d = sout_valid;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt;
    unique case (state_q)
      IDLE: begin
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        if (in_valid && in_ready) begin
          state_d = PRE;
          pre_d   = PREAMBLE;
          shreg_d = in_data;
          idx_d   = '0;
        end
      end
      PRE: begin
        if (bit_en) begin
          sout_d       = pre_q[PRE_W-1];
          sout_valid_d = 1'b1;
          pre_d        = pre_q << 1;
          if (idx_q == IDX_W'(PRE_W - 1)) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DATA: begin
        if (bit_en) begin
          sout_d       = shreg_q[DATA_W-1];
          sout_valid_d = 1'b1;
          shreg_d      = shreg_q << 1;
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            state_d = GAP;
            idx_d   = '0;
            gap_d   = GAP_W'(GAP_LEN);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      GAP: begin
        if (bit_en) begin
          sout_d       = 1'b0;
          sout_valid_d = 1'b0;
          if (gap_q == '0) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt + CNT_W'(1);
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: slot-queue reference model compared every cycle,
// directed scenarios with literal expectations, and a small-counter/no-gap instance.
module tb_seq_pattern_gen;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned PRE_W   = 4;
  localparam int unsigned GAP_LEN = 2;
  localparam int unsigned CNT_W   = 8;
  localparam logic [3:0]  PRE_PAT = 4'b1010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic              rst = 1'b1, bit_en = 1'b1, in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready, sout, sout_valid, busy, frame_done;
  logic [CNT_W-1:0]  frame_cnt;

  seq_pattern_gen u_dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sout(sout), .sout_valid(sout_valid), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  // Two-bit counter, zero-gap instance
  logic       rst2 = 1'b1, bit_en2 = 1'b1, in_valid2 = 1'b0;
  logic [7:0] in_data2 = '0;
  logic       in_ready2, sout2, sout_valid2, busy2, frame_done2;
  logic [1:0] frame_cnt2;

  seq_pattern_gen #(.CNT_W(2), .GAP_LEN(0)) u_dut2 (
    .clk(clk), .rst(rst2), .bit_en(bit_en2), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .sout(sout2), .sout_valid(sout_valid2), .busy(busy2),
    .frame_done(frame_done2), .frame_cnt(frame_cnt2)
  );

  int nchecks = 0;
  int nfail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: an accepted payload becomes a queue of {valid,bit} slots,
  // one slot consumed per bit_en edge; the frame ends when the queue drains.
  logic [1:0]       q[$];
  logic [1:0]       slot;
  logic             m_busy = 1'b0, m_sout = 1'b0, m_sv = 1'b0, m_done = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      q.delete();
      m_busy = 1'b0; m_sout = 1'b0; m_sv = 1'b0; m_cnt = '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        for (int i = PRE_W - 1; i >= 0; i--) q.push_back({1'b1, PRE_PAT[i]});
        for (int i = DATA_W - 1; i >= 0; i--) q.push_back({1'b1, in_data[i]});
        for (int i = 0; i <= int'(GAP_LEN); i++) q.push_back(2'b00);
        m_busy = 1'b1;
      end
    end else if (bit_en) begin
      slot   = q.pop_front();
      m_sv   = slot[1];
      m_sout = slot[0];
      if (q.size() == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_cnt  = m_cnt + 8'd1;
      end
    end
  end

  // Per-cycle comparison against the model
  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en)
      check("outputs_vs_model",
            32'({in_ready, busy, sout, sout_valid, frame_done, frame_cnt}),
            32'({~m_busy, m_busy, m_sout, m_sv, m_done, m_cnt}));
  end

  // Bit-rate strobe generator: 0=always, 1=every third cycle, 2=random
  int be_mode = 0;
  int be_ph   = 0;
  initial forever begin
    @(negedge clk);
    case (be_mode)
      0: bit_en = 1'b1;
      1: begin bit_en = (be_ph == 0); be_ph = (be_ph + 1) % 3; end
      default: bit_en = 1'($urandom_range(0, 1));
    endcase
  end

  // Behavioural 1010 detector with a registered z, fed from sout once per bit period
  logic       det_en = 1'b0;
  logic [3:0] hist = '0;
  logic       z_reg = 1'b0;
  int         vbits = 0;
  int         zcnt  = 0;
  always @(negedge clk) begin
    if (det_en) begin
      if (!busy) vbits = 0;
      else if (sout_valid) vbits++;
      if (z_reg) begin
        zcnt++;
        check("det_z_at_first_payload_bit", 32'(vbits), 32'd5);
      end
      hist  = {hist[2:0], sout};
      z_reg = (hist == 4'b1010);
    end
  end

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 500) begin @(negedge clk); n++; end
    check("send_accept_timeout", 32'(n < 500), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 1000) begin @(negedge clk); n++; end
    check("wait_idle_timeout", 32'(n < 1000), 32'd1);
  endtask

  logic [11:0] cap;
  int          n, rdy_bad;
  int          exp2[5] = '{1, 2, 3, 0, 1};

  initial begin
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    check("reset_state", 32'({in_ready, busy, sout, sout_valid, frame_done, frame_cnt}),
          32'(13'b1_0_0_0_0_00000000));

    // Frame of 8'hA5 with bit_en always high
    be_mode = 0;
    send(8'hA5);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cap[11-i] = sout;
    end
    check("a5_bitstream", 32'(cap), 32'h00000AA5);
    n = 0;
    while (!frame_done && n < 50) begin @(negedge clk); n++; end
    check("a5_done_latency", 32'(n), 32'd3);
    check("a5_cnt", 32'(frame_cnt), 32'd1);
    check("a5_ready_after_done", 32'(in_ready), 32'd1);

    // Paced frame of 8'hFF
    be_mode = 1;
    send(8'hFF);
    wait_idle();
    check("pace_cnt", 32'(frame_cnt), 32'd2);

    // Held in_valid: 3C then C3 back-to-back
    be_mode = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    n = 0;
    while (in_ready && n < 50) begin @(negedge clk); n++; end
    in_data = 8'hC3;
    rdy_bad = 0;
    n = 0;
    while (!frame_done && n < 200) begin
      if (in_ready) rdy_bad++;
      @(negedge clk);
      n++;
    end
    check("hs_ready_low_in_frame1", 32'(rdy_bad), 32'd0);
    check("hs_ready_at_done", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("hs_c3_accepted_next_edge", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_idle();
    check("hs_cnt", 32'(frame_cnt), 32'd4);

    // Reset during the payload bits of 8'h5A
    send(8'h5A);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_frame_state", 32'({sout, sout_valid, busy, frame_cnt}), 32'd0);
    send(8'h5A);
    wait_idle();
    check("rst_then_frame_cnt", 32'(frame_cnt), 32'd1);

    // Detector end-to-end with zero payloads
    det_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send(8'h00);
      wait_idle();
    end
    repeat (3) @(negedge clk);
    det_en = 1'b0;
    check("det_one_z_per_frame", 32'(zcnt), 32'd3);

    // Randomized traffic, strobes and occasional resets
    be_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 9) < 3);
      in_data  = 8'($urandom);
      rst      = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    wait_idle();

    // Zero-gap instance with 2-bit frame counter
    rst2 = 1'b1;
    repeat (2) @(negedge clk);
    rst2 = 1'b0;
    check("w_reset_cnt", 32'(frame_cnt2), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid2 = 1'b1;
      in_data2  = 8'h00;
      @(negedge clk);
      in_valid2 = 1'b0;
      n = 0;
      while (!frame_done2 && n < 100) begin @(negedge clk); n++; end
      check("w_frame_edges", 32'(n), 32'd13);
      check("w_frame_cnt", 32'(frame_cnt2), 32'(exp2[k]));
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial frame transmitter: the generating end of the 1010 sync-marker bit stream.
- Accepts a parallel payload word on a valid/ready handshake.
- Emits PREAMBLE (default 1010) then the payload MSB-first on a single serial line, one bit per bit_en strobe, followed by an idle-zero gap.
- Feeds the x input of the 1010 sequence detector and acts as the bit source for detector verification.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- PRE_W, 4, preamble width in bits (>=1).
- PREAMBLE, 4'b1010, preamble pattern, sent MSB first.
- GAP_LEN, 2, extra zero bit slots after the payload (>=0).
- CNT_W, 8, width of the frame counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- bit_en  in  1  bit-rate strobe; the serial state advances only on edges where bit_en=1.
- in_valid  in  1  payload offer.
- in_data  in  DATA_W  payload; sampled on the accept edge.
- in_ready  out  1  high when a payload can be accepted.
- sout  out  1  serial data, registered.
- sout_valid  out  1  high while sout carries a preamble or payload bit, registered.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes, registered.
- frame_cnt  out  CNT_W  number of completed frames, wraps modulo 2^CNT_W.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, sout=0, sout_valid=0, frame_done=0, frame_cnt=0, shift register=0, counters=0.
- Reset has priority over all other inputs, including mid-frame; a frame in progress is aborted and is not counted.
- FSM states are IDLE, PRE, DATA and GAP.
- in_ready = (state==IDLE), decoded from the state register only. busy = !in_ready.
- IDLE:
  - sout=0 and sout_valid=0.
  - On an edge with in_valid && in_ready: latch in_data into the shift register, set the bit index to 0, and go to PRE.
  - Acceptance does not depend on bit_en.
- PRE, on each bit_en edge:
  - sout <= PREAMBLE[PRE_W-1-idx] and sout_valid <= 1, then idx++.
  - After PRE_W bits, go to DATA with idx=0.
- DATA, on each bit_en edge:
  - sout <= shreg[DATA_W-1] and sout_valid <= 1, then shift the register left.
  - After DATA_W bits, go to GAP with gap counter g=GAP_LEN.
- GAP, on each bit_en edge:
  - sout <= 0 and sout_valid <= 0.
  - If g==0: go to IDLE, pulse frame_done (high for exactly one cycle after this edge), and frame_cnt <= frame_cnt+1 (wrapping).
  - Otherwise g--.
- Hold rule: on edges with bit_en=0, sout, sout_valid, indices and state hold. The accept transition out of IDLE is the only exception.
- Frame length: PRE_W+DATA_W+GAP_LEN+1 bit_en edges after the accept edge. Each emitted bit stays stable from its bit_en edge until the next bit_en edge.
- Back-to-back frames: the next payload can be accepted no earlier than the edge after the frame_done edge. The guaranteed zero time between frames is at least GAP_LEN bit periods.
- in_data changes while busy are ignored; the payload is captured only on the accept edge.
- With GAP_LEN=0, the single GAP edge drives sout to 0 and completes the frame.

Test Plan:
- Default params, bit_en=1, in_valid pulse with in_data=8'hA5 at edge c0:
  - sout on c1..c12 = 1,0,1,0, 1,0,1,0,0,1,0,1; sout_valid=1 on c1..c12.
  - sout=0 from c13; frame_done high only in the cycle after c15; frame_cnt=1; in_ready high after c15.
- Pacing: bit_en high every 3rd cycle, in_data=8'hFF.
  - Each bit is held exactly 3 cycles.
  - sout shows 1,0,1,0 then eight 1s; no bit changes on bit_en=0 edges.
- Handshake: in_valid held high with in_data=8'h3C, then 8'hC3.
  - in_ready=0 throughout frame 1; 8'hC3 is accepted on the first edge after the frame_done edge.
  - 8'hC3 is serialized intact; frame_cnt=2.
- Reset mid-frame: assert rst for one cycle during the DATA bits of 8'h5A.
  - The next cycle shows sout=0, sout_valid=0, busy=0 and frame_cnt unchanged (0); no frame_done pulse.
  - A new frame sent afterwards is correct.
- Wrap and GAP_LEN=0 (CNT_W=2, GAP_LEN=0): send 5 frames of 8'h00.
  - Each frame takes 13 bit_en edges after accept.
  - frame_cnt goes 1,2,3,0,1.
- End-to-end: drive sout into the 1010 detector's x input, payload 8'h00.
  - Exactly one z pulse per frame, at the first payload bit (the 0 after the preamble).
